fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage directly upstream of `dec`. It owns the program counter and reads each 32-bit instruction one byte per cycle from the byte-wide program memory, assembling the bytes big-endian. It presents the word with its PC to the decoder over a valid/ready handshake. It accepts jump redirects from the ALU stage and a run/halt control from the syscall stage.

## Interface
Parameters:
- `RESET_PC`, default 32'h0: PC loaded on reset.
- `ADDR_W`, default 32: address/PC width (PC arithmetic is modulo 2^ADDR_W).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `run`  in  1  1 = fetching permitted; 0 = halt request (syscall 0).
- `redir_valid`  in  1  jump taken this cycle.
- `redir_pc`  in  ADDR_W  jump target.
- `mem_req`  out  1  byte read request.
- `mem_addr`  out  ADDR_W  byte address.
- `mem_rdata`  in  8  read data, valid exactly one cycle after `mem_req`.
- `ir`  out  32  assembled instruction, `{b0,b1,b2,b3}`, b0 at lowest address.
- `ir_pc`  out  ADDR_W  address of `ir`.
- `ir_valid`  out  1  `ir`/`ir_pc` valid.
- `ir_ready`  in  1  decoder accepts.
- `fault`  out  1  sticky misaligned-fetch flag (only with macro, else tied 0).

## Operation
- States: FETCH, WAIT, HOLD, HALT.
- FETCH issues bytes: cnt 0..3, `mem_req`=1, `mem_addr`=pc+cnt. Each returned byte shifts into the assembler on the following cycle.
- FETCH is followed by one WAIT cycle to capture byte 3. Then `ir`, `ir_pc`=pc, and `ir_valid`=1 are registered, and the state becomes HOLD.
- HOLD: outputs stable while `ir_valid && !ir_ready`. On handshake: pc <= pc+4, next state FETCH if `run`=1, else HALT.
- HALT: no requests, `ir_valid`=0. Leaves to FETCH when `run`=1 or `redir_valid`=1.
- `run` is sampled only at word boundaries. A fetch in progress always completes and is presented.
- Redirect has priority in every state:
  - pc <= `redir_pc`; in-flight bytes discarded; `ir_valid` cleared next cycle; next state FETCH.
  - A handshake in the same cycle as a redirect counts as a completed transfer. The pc+4 increment is superseded by `redir_pc`.
- Bytes returned for an aborted fetch, arriving the cycle after the redirect, are ignored.
- Reset mid-operation aborts everything. Outputs go to reset values immediately (asynchronous).

## Timing
- Reset values: `mem_req`=0, `mem_addr`=0, `ir`=0, `ir_pc`=RESET_PC, `ir_valid`=0, `fault`=0, state FETCH, pc=RESET_PC, cnt=0.
- First `mem_req` in the first cycle after `rst` deasserts (cycle 0).
- Requests occur in cycles 0–3, data arrives in cycles 1–4, and `ir_valid` rises in cycle 5.
- Handshake at cycle t: next `mem_req` at t+1, next `ir_valid` at t+6. Throughput is one instruction per 6 cycles with `ir_ready` held high.
- Redirect at cycle t: `mem_req` for `redir_pc` at t+1; `ir_valid`=0 from t+1.
- PC wraps: 32'hFFFFFFFC + 4 = 0. Byte addresses pc+cnt also wrap modulo 2^ADDR_W.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - At each FETCH entry, if pc[1:0]≠0, no request is issued and `fault` is set (sticky).
  - The state goes to HALT and stays there regardless of `run`/redirect until `rst`.
- Undefined: unaligned PCs are fetched byte-wise normally and `fault` is constant 0.

## Structure
- Package `fetch_pkg`:
  - state enum (FETCH, WAIT, HOLD, HALT)
  - `INSN_BYTES`=4
  - `FETCH_RESET_PC` default constant
- Sub-module `byte_assembler`: 4-byte shift register with load/clear and a byte-count-complete flag.
- The FSM, PC and handshake logic stay in `fetch_unit`.

## Test plan
- Reset, memory bytes 0..3 = 12 34 56 78, `ir_ready`=1 → requests at addresses 0,1,2,3 in cycles 0–3; `ir_valid` in cycle 5 with `ir`=32'h12345678, `ir_pc`=0; next request address 4 in cycle 6.
- `ir_ready`=0 for 10 cycles after `ir_valid` → `ir`/`ir_pc` stable, no `mem_req`; on release, pc advances by exactly 4.
- `redir_valid`, `redir_pc`=32'h40 asserted in cycle 2 of a fetch → cycle 3 requests address 0x40; first presented `ir_pc`=0x40; no partial word is ever valid.
- `run`=0 mid-fetch at pc 8 → word at 8 is presented, then HALT with no requests; `run`=1 → fetch resumes at 0xC.
- pc=32'hFFFFFFFC → requests FFFFFFFC..FFFFFFFF, then next word fetched from address 0.
- With `FETCH_ALIGN_CHECK_EN`, redirect to 32'h42 → `fault`=1 the next cycle, no `mem_req`, stuck until `rst`. Without the macro → bytes 0x42..0x45 fetched, `fault`=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and constants for the instruction fetch stage
package fetch_pkg;
  typedef enum logic [1:0] {FETCH, WAIT, HOLD, HALT} state_t;
  localparam int INSN_BYTES = 4;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0;
endpackage

// File: rtl/fetch_unit_byte_assembler.sv
// byte_assembler: shifts instruction bytes in first-byte-most-significant and flags a complete word
module byte_assembler
  import fetch_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    load,
  input  logic [7:0]              din,
  output logic [8*INSN_BYTES-1:0] word,
  output logic                    full
);
  logic [2:0] cnt;
  // clear wins over load so a byte landing in the same cycle as an abort is dropped
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      word <= '0;
      cnt  <= '0;
    end else if (clr) begin
      word <= '0;
      cnt  <= '0;
    end else if (load) begin
      word <= {word[8*INSN_BYTES-9:0], din};
      cnt  <= cnt + 3'd1;
    end
  assign full = cnt == 3'(INSN_BYTES);
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: byte-serial big-endian instruction fetch with redirect and run/halt; FETCH_ALIGN_CHECK_EN adds a sticky misaligned-PC fault
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [31:0]       ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic              fault
);
  state_t            state, nxt;
  logic [ADDR_W-1:0] pc, nxt_pc;
  logic [1:0]        cnt;
  logic              pend, hs, full, set_fault, fault_q;

  assign hs = state == HOLD && ir_ready;

  byte_assembler u_asm (
    .clk  (clk),
    .rst  (rst),
    .clr  (redir_valid || hs),
    .load (pend),
    .din  (mem_rdata),
    .word (ir),
    .full (full)
  );

  // state, pc, byte counter, outstanding-read flag and presented pc
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      cnt     <= '0;
      pend    <= 1'b0;
      ir_pc   <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state   <= nxt;
      pc      <= nxt_pc;
      cnt     <= (state == FETCH && nxt == FETCH && !redir_valid) ? cnt + 2'd1 : 2'd0;
      pend    <= mem_req && !redir_valid;
      ir_pc   <= state == WAIT ? pc : ir_pc;
      fault_q <= fault_q || set_fault;
    end

  // next state and pc; a redirect overrides everything except a latched fault
  always_comb begin
    nxt       = state;
    nxt_pc    = pc;
    set_fault = 1'b0;
    unique case (state)
      FETCH: nxt = cnt == 2'(INSN_BYTES - 1) ? WAIT : FETCH;
      WAIT:  nxt = HOLD;
      HOLD:  if (ir_ready) begin
               nxt    = run ? FETCH : HALT;
               nxt_pc = pc + ADDR_W'(INSN_BYTES);
             end
      HALT:  nxt = run ? FETCH : HALT;
      default: nxt = FETCH;
    endcase
    if (redir_valid) begin
      nxt    = FETCH;
      nxt_pc = redir_pc;
    end
`ifdef FETCH_ALIGN_CHECK_EN
    if (fault_q) nxt = HALT;
    else if (nxt == FETCH && nxt_pc[1:0] != 2'b00) begin
      nxt       = HALT;
      set_fault = 1'b1;
    end
`endif
  end

  // requests and presentation follow the registered state and are forced idle during reset
  always_comb begin
    mem_req = state == FETCH && !rst;
`ifdef FETCH_ALIGN_CHECK_EN
    mem_req = mem_req && pc[1:0] == 2'b00;
`endif
    mem_addr = mem_req ? pc + ADDR_W'(cnt) : '0;
    ir_valid = state == HOLD && full;
  end

  assign fault = fault_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed table, corner-case sequences and randomized run against a cycle-offset reference model
module tb_fetch_unit;
  logic        clk = 1'b0, rst = 1'b0, run = 1'b1, redir_valid = 1'b0, ir_ready = 1'b1;
  logic [31:0] redir_pc = '0;
  logic        mem_req, ir_valid, fault;
  logic [31:0] mem_addr, ir, ir_pc;
  logic [7:0]  mem_rdata = '0;
  int          n_cmp = 0, n_bad = 0;

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] ir;
    logic [31:0] pc;
  } vec_t;
  vec_t tbl[16];

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .run(run), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mb(input logic [31:0] a);
    logic [31:0] seed;
    seed = 32'h12345678;
    if (a < 32'd4) return seed[8*(3-int'(a[1:0])) +: 8];
    return a[7:0] * 8'd13 + a[15:8] + a[31:24] + 8'h5B;
  endfunction

  function automatic logic [31:0] word(input logic [31:0] a);
    return {mb(a), mb(a + 32'd1), mb(a + 32'd2), mb(a + 32'd3)};
  endfunction

  function automatic vec_t mk(input logic r, input logic [31:0] rp, input logic q,
                              input logic [31:0] ad, input logic v, input logic [31:0] w,
                              input logic [31:0] p);
    vec_t t;
    t.redir = r; t.rpc = rp; t.req = q; t.addr = ad; t.vld = v; t.ir = w; t.pc = p;
    return t;
  endfunction

  always @(posedge clk) mem_rdata <= mem_req ? mb(mem_addr) : 8'hA5;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    #1;
    chk1("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_ir_pc", ir_pc, 32'h0);
    chk1("rst_ir_valid", ir_valid, 1'b0);
    chk1("rst_fault", fault, 1'b0);
    run = 1'b1; redir_valid = 1'b0; ir_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_valid(input int lim);
    int k = 0;
    while (!ir_valid && k < lim) begin
      step();
      k++;
    end
    chk1("ir_valid_timeout", ir_valid, 1'b1);
  endtask

  initial begin
    logic [31:0] mpc;
    int          age;
    bit          halted, exp_req, exp_vld;
    for (int i = 0; i < 4; i++) tbl[i] = mk(0, 0, 1, 32'(i), 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 1, 32'h12345678, 32'h0);
    tbl[6]  = mk(0, 0, 1, 32'h4, 0, 0, 0);
    tbl[7]  = mk(0, 0, 1, 32'h5, 0, 0, 0);
    tbl[8]  = mk(1, 32'h40, 1, 32'h6, 0, 0, 0);
    for (int i = 0; i < 4; i++) tbl[9+i] = mk(0, 0, 1, 32'h40 + 32'(i), 0, 0, 0);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0);
    tbl[14] = mk(0, 0, 0, 0, 1, word(32'h40), 32'h40);
    tbl[15] = mk(0, 0, 1, 32'h44, 0, 0, 0);

    step();
    reset_dut();
    for (int i = 0; i < 16; i++) begin
      redir_valid = tbl[i].redir;
      redir_pc    = tbl[i].rpc;
      chk1($sformatf("tbl%0d_req", i), mem_req, tbl[i].req);
      if (tbl[i].req) chk($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].addr);
      chk1($sformatf("tbl%0d_valid", i), ir_valid, tbl[i].vld);
      if (tbl[i].vld) begin
        chk($sformatf("tbl%0d_ir", i), ir, tbl[i].ir);
        chk($sformatf("tbl%0d_ir_pc", i), ir_pc, tbl[i].pc);
      end
      step();
    end
    redir_valid = 1'b0;

    ir_ready = 1'b0;
    wait_valid(10);
    for (int i = 0; i < 10; i++) begin
      chk1("stall_valid", ir_valid, 1'b1);
      chk("stall_ir", ir, word(32'h44));
      chk("stall_ir_pc", ir_pc, 32'h44);
      chk1("stall_no_req", mem_req, 1'b0);
      step();
    end
    ir_ready = 1'b1;
    chk1("stall_release_valid", ir_valid, 1'b1);
    step();
    chk1("after_stall_req", mem_req, 1'b1);
    chk("after_stall_addr", mem_addr, 32'h48);

    redir_valid = 1'b1; redir_pc = 32'h8;
    step();
    redir_valid = 1'b0;
    chk("halt_fetch_addr", mem_addr, 32'h8);
    run = 1'b0;
    step();
    wait_valid(10);
    chk("halt_word_pc", ir_pc, 32'h8);
    chk("halt_word_ir", ir, word(32'h8));
    step();
    for (int i = 0; i < 5; i++) begin
      chk1("halted_no_req", mem_req, 1'b0);
      chk1("halted_no_valid", ir_valid, 1'b0);
      step();
    end
    run = 1'b1;
    step();
    chk1("resume_req", mem_req, 1'b1);
    chk("resume_addr", mem_addr, 32'hC);

    redir_valid = 1'b1; redir_pc = 32'hFFFFFFFC;
    step();
    redir_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk1("wrap_req", mem_req, 1'b1);
      chk("wrap_addr", mem_addr, 32'hFFFFFFFC + 32'(k));
      step();
    end
    wait_valid(4);
    chk("wrap_ir_pc", ir_pc, 32'hFFFFFFFC);
    chk("wrap_ir", ir, word(32'hFFFFFFFC));
    step();
    chk1("wrapped_req", mem_req, 1'b1);
    chk("wrapped_addr", mem_addr, 32'h0);

    redir_valid = 1'b1; redir_pc = 32'h42;
    step();
    redir_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    chk1("align_fault", fault, 1'b1);
    chk1("align_no_req", mem_req, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk1("stuck_no_req", mem_req, 1'b0);
      chk1("stuck_fault", fault, 1'b1);
      chk1("stuck_no_valid", ir_valid, 1'b0);
      redir_valid = i[0]; redir_pc = 32'h100; run = 1'b1;
      step();
    end
    redir_valid = 1'b0;
    reset_dut();
    chk1("fault_cleared_req", mem_req, 1'b1);
`else
    for (int k = 0; k < 4; k++) begin
      chk("unaligned_addr", mem_addr, 32'h42 + 32'(k));
      chk1("unaligned_no_fault", fault, 1'b0);
      step();
    end
    wait_valid(4);
    chk("unaligned_ir", ir, word(32'h42));
    chk("unaligned_ir_pc", ir_pc, 32'h42);
`endif

    reset_dut();
    mpc = 32'h0; age = 0; halted = 1'b0;
    for (int n = 0; n < 400; n++) begin
      exp_req = !halted && age < 4;
      exp_vld = !halted && age == 5;
      chk1("rnd_req", mem_req, exp_req);
      if (exp_req) chk("rnd_addr", mem_addr, mpc + 32'(age));
      chk1("rnd_valid", ir_valid, exp_vld);
      if (exp_vld) begin
        chk("rnd_ir", ir, word(mpc));
        chk("rnd_ir_pc", ir_pc, mpc);
      end
      run         = $urandom_range(0, 4) != 0;
      ir_ready    = $urandom_range(0, 1) == 1;
      redir_valid = $urandom_range(0, 11) == 0;
      redir_pc    = $urandom;
`ifdef FETCH_ALIGN_CHECK_EN
      redir_pc[1:0] = 2'b00;
`endif
      if (redir_valid) begin
        mpc = redir_pc; halted = 1'b0; age = 0;
      end else if (halted) begin
        if (run) begin halted = 1'b0; age = 0; end
      end else if (age == 5) begin
        if (ir_ready) begin mpc = mpc + 32'd4; age = 0; halted = !run; end
      end else age++;
      step();
    end
    redir_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
